// File: rtl/frame_buffer_eth_reader.sv
// Streams the frame buffer out as one packet per row: SOF, row index,
// H_PIXELS pixel bytes and an XOR checksum, fed by a BRAM prefetch queue.
module frame_buffer_eth_reader #(
  parameter int          H_PIXELS     = 320,
  parameter int          V_PIXELS     = 240,
  parameter int          BRAM_LATENCY = 2,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          GAP_CYCLES   = 12,
  parameter logic [7:0]  SOF_BYTE     = 8'hA5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  output logic [16:0] pixel_addr_out,
  input  logic [7:0]  pixel_from_bram,
  output logic [7:0]  axiod,
  output logic        axiov,
  input  logic        axiir,
  output logic        axiolast,
  output logic        busy_out,
  output logic        frame_done_out
);

  localparam int TOTAL = H_PIXELS * V_PIXELS;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(H_PIXELS + 1);
  localparam int GW    = $clog2(GAP_CYCLES + 1);
  localparam int SW    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_ROW,
    S_PIXELS,
    S_CHECK,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [16:0]           r_rd_addr;
  logic                  r_rd_done;
  logic [BRAM_LATENCY-1:0] r_tag;
  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_count;
  logic [7:0]            r_row;
  logic [CW-1:0]         r_col;
  logic [GW-1:0]         r_gap;
  logic [7:0]            r_csum;
  logic                  r_frame_done;

  logic                  w_busy;
  logic                  w_xfer;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [7:0]            w_head;
  logic [SW-1:0]         w_inflight;
  logic [SW-1:0]         w_used;

  assign w_busy         = (r_state != S_IDLE);
  assign w_xfer         = axiov && axiir;
  assign w_empty        = (r_count == '0);
  assign w_head         = r_mem[r_rptr];
  assign w_push         = r_tag[BRAM_LATENCY-1];
  assign w_pop          = (r_state == S_PIXELS) && !w_empty && axiir;
  assign busy_out       = w_busy;
  assign frame_done_out = r_frame_done;
  assign pixel_addr_out = r_rd_addr;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      w_inflight = w_inflight + SW'(r_tag[i]);
    end
  end

  // Credit reads in flight as occupied so returning data always has a slot
  assign w_used  = SW'(r_count) + w_inflight;
  assign w_issue = w_busy && !r_rd_done &&
                   (w_used < SW'(FIFO_DEPTH));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    axiod    = '0;
    axiov    = 1'b0;
    axiolast = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_in) w_next = S_SOF;
      end
      S_SOF: begin
        axiod = SOF_BYTE;
        axiov = 1'b1;
        if (axiir) w_next = S_ROW;
      end
      S_ROW: begin
        axiod = r_row;
        axiov = 1'b1;
        if (axiir) w_next = S_PIXELS;
      end
      S_PIXELS: begin
        axiod = w_head;
        axiov = !w_empty;
        if (w_pop && r_col == CW'(H_PIXELS - 1)) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        axiod    = r_csum;
        axiov    = 1'b1;
        axiolast = 1'b1;
        if (axiir) w_next = S_GAP;
      end
      S_GAP: begin
        if (r_gap == GW'(GAP_CYCLES - 1)) begin
          if (r_row == 8'(V_PIXELS - 1)) w_next = S_IDLE;
          else                           w_next = S_SOF;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rd_addr    <= '0;
      r_rd_done    <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_gap        <= '0;
      r_csum       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == S_GAP) && (w_next == S_IDLE);
      if (w_issue) begin
        if (r_rd_addr == 17'(TOTAL - 1)) r_rd_done <= 1'b1;
        else                             r_rd_addr <= r_rd_addr + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_row     <= '0;
            r_rd_addr <= '0;
            r_rd_done <= 1'b0;
          end
        end
        S_SOF: begin
          if (w_xfer) begin
            r_csum <= '0;
            r_col  <= '0;
          end
        end
        S_ROW: begin
          if (w_xfer) r_csum <= r_row;
        end
        S_PIXELS: begin
          if (w_pop) begin
            r_csum <= r_csum ^ w_head;
            r_col  <= r_col + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_xfer) r_gap <= '0;
        end
        S_GAP: begin
          r_gap <= r_gap + 1'b1;
          if (w_next == S_SOF) r_row <= r_row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag pipeline mirrors the BRAM latency; clearing it drops stale returns
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_tag   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_tag[0] <= w_issue;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wptr] <= pixel_from_bram;
  end

endmodule

// File: tb/tb_frame_buffer_eth_reader.sv
// Scoreboard bench: frames are queued as expected bytes, monitors pop on
// every stream transfer. Main instance 32x10, second instance 8x2.
`timescale 1ns/1ps
module tb_frame_buffer_eth_reader;
  localparam int H = 32, V = 10, GAP = 12, DEPTH = 4;
  localparam int H2 = 8, V2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, axiir, start2, axiir2;
  logic [16:0] addr, addr2;
  logic [7:0] bram_d, axiod, bram_d2, axiod2;
  logic axiov, axiolast, busy, done;
  logic axiov2, axiolast2, busy2, done2;
  logic [7:0] b1, b2, c1, c2;

  always @(posedge clk) begin
    b1 <= addr[7:0];
    b2 <= b1;
    c1 <= addr2[7:0];
    c2 <= c1;
  end
  assign bram_d  = b2;
  assign bram_d2 = c2;

  frame_buffer_eth_reader #(
    .H_PIXELS(H), .V_PIXELS(V), .BRAM_LATENCY(2),
    .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .SOF_BYTE(8'hA5)
  ) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .pixel_addr_out(addr), .pixel_from_bram(bram_d),
    .axiod(axiod), .axiov(axiov), .axiir(axiir),
    .axiolast(axiolast), .busy_out(busy), .frame_done_out(done)
  );

  frame_buffer_eth_reader #(
    .H_PIXELS(H2), .V_PIXELS(V2), .BRAM_LATENCY(2),
    .FIFO_DEPTH(4), .GAP_CYCLES(GAP), .SOF_BYTE(8'hA5)
  ) dut2 (
    .clk_in(clk), .rst_in(rst), .start_in(start2),
    .pixel_addr_out(addr2), .pixel_from_bram(bram_d2),
    .axiod(axiod2), .axiov(axiov2), .axiir(axiir2),
    .axiolast(axiolast2), .busy_out(busy2), .frame_done_out(done2)
  );

  int checks = 0, errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp2_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int hp, input int vp, input bit second);
    logic [8:0] x;
    logic [7:0] cs;
    int a;
    for (int r = 0; r < vp; r++) begin
      x = {1'b0, 8'hA5};
      if (second) exp2_q.push_back(x); else exp_q.push_back(x);
      cs = 8'(r);
      x = {1'b0, 8'(r)};
      if (second) exp2_q.push_back(x); else exp_q.push_back(x);
      for (int c = 0; c < hp; c++) begin
        a = r * hp + c;
        cs = cs ^ 8'(a);
        x = {1'b0, 8'(a)};
        if (second) exp2_q.push_back(x); else exp_q.push_back(x);
      end
      x = {1'b1, cs};
      if (second) exp2_q.push_back(x); else exp_q.push_back(x);
    end
  endtask

  // main-instance monitor state
  bit rdy_rand = 0;
  int done_cnt = 0, pkt_idx = 0, pkts_seen = 0;
  int gap_cnt = 0, inc_cnt = 0, pop_cnt = 0, max_out = 0;
  bit gap_armed = 0, pv = 0, pr = 0, pl = 0;
  logic [7:0] pd = '0;
  logic [16:0] prev_addr = '0;
  logic [8:0] e;

  initial begin
    axiir = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      axiir = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pv = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(axiov), 1);
        chk("hold_data", {23'b0, axiolast, axiod}, {23'b0, pl, pd});
      end
      if (addr == prev_addr + 17'd1) inc_cnt++;
      prev_addr = addr;
      if (gap_armed) begin
        if (!axiov) gap_cnt++;
        else begin
          chk("gap_len", gap_cnt, GAP);
          gap_armed = 0;
        end
      end
      if (axiov && axiir) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %02h expected none", axiod);
        end else begin
          e = exp_q.pop_front();
          chk("stream_byte", {23'b0, axiolast, axiod}, {23'b0, e});
        end
        if (pkt_idx >= 2 && !axiolast) pop_cnt++;
        if (axiolast) begin
          pkt_idx = 0;
          pkts_seen++;
          gap_armed = 1;
          gap_cnt = 0;
        end else begin
          pkt_idx++;
        end
      end
      if (inc_cnt - pop_cnt > max_out) max_out = inc_cnt - pop_cnt;
      if (done) begin
        done_cnt++;
        gap_armed = 0;
        chk("busy_falls_with_done", 32'(busy), 0);
        chk("queue_empty_at_done", exp_q.size(), 0);
        chk("fifo_bound", 32'(max_out <= DEPTH), 1);
      end
      pv = axiov; pr = axiir; pd = axiod; pl = axiolast;
    end
  end

  // second-instance monitor state
  int done2_cnt = 0, inc2 = 0, bytes2 = 0;
  logic [16:0] paddr2 = '0, max2 = '0;
  logic [15:0] seen2 = '0;
  logic [8:0] e2;

  always @(negedge clk) begin
    if (!rst) begin
      if (addr2 == paddr2 + 17'd1) inc2++;
      paddr2 = addr2;
      if (addr2 > max2) max2 = addr2;
      if (addr2 < 17'd16) seen2[addr2[3:0]] = 1'b1;
      if (axiov2 && axiir2) begin
        bytes2++;
        if (exp2_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte2: got %02h expected none", axiod2);
        end else begin
          e2 = exp2_q.pop_front();
          chk("stream_byte2", {23'b0, axiolast2, axiod2}, {23'b0, e2});
        end
      end
      if (done2) done2_cnt++;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    inc_cnt = 0; pop_cnt = 0; max_out = 0;
    pkts_seen = 0; pkt_idx = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == n0; i++) @(posedge clk);
    chk("frame_done_seen", 32'(done_cnt != n0), 1);
  endtask

  initial begin
    int saved;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; axiir2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_axiod", 32'(axiod), 0);
    chk("rst_axiov", 32'(axiov), 0);
    chk("rst_axiolast", 32'(axiolast), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(addr), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // frame 1: always ready, second start at cycle 100 is ignored
    push_frame(H, V, 0);
    pulse_start();
    repeat (98) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(4000);
    repeat (40) @(posedge clk);
    chk("one_done_frame1", done_cnt, 1);
    chk("idle_after_frame1", 32'(busy), 0);
    chk("packets_frame1", pkts_seen, V);

    // frame 2: random ready
    rdy_rand = 1;
    push_frame(H, V, 0);
    pulse_start();
    wait_done(8000);
    chk("packets_frame2", pkts_seen, V);
    rdy_rand = 0;
    repeat (5) @(posedge clk);

    // frame 3: reset mid-PIXELS of row 5
    push_frame(H, V, 0);
    pulse_start();
    for (int i = 0; i < 4000 && !(pkts_seen == 5 && pkt_idx >= 10); i++)
      @(posedge clk);
    chk("reached_row5", pkts_seen, 5);
    saved = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    pkt_idx = 0;
    gap_armed = 0;
    @(negedge clk);
    chk("mid_rst_axiod", 32'(axiod), 0);
    chk("mid_rst_axiov", 32'(axiov), 0);
    chk("mid_rst_axiolast", 32'(axiolast), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", 32'(addr), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    chk("no_done_after_reset", done_cnt, saved);

    // frame 4: clean restart from row 0, address 0
    push_frame(H, V, 0);
    pulse_start();
    wait_done(4000);
    chk("packets_frame4", pkts_seen, V);

    // small instance: 2 packets of 11 bytes, addresses 0..15 once each
    push_frame(H2, V2, 1);
    @(posedge clk);
    #1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int i = 0; i < 500 && done2_cnt == 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    chk("small_done", done2_cnt, 1);
    chk("small_bytes", bytes2, 22);
    chk("small_queue_empty", exp2_q.size(), 0);
    chk("small_addr_incs", inc2, 15);
    chk("small_addr_max", 32'(max2), 15);
    chk("small_addr_seen", 32'(seen2), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
